lcd_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the nibble-level LCD controller. It owns the `rs`, `rw`, `datain` and `start` inputs of that controller. After reset it waits out the HD44780 power-up delay and plays a fixed 4-bit-mode init sequence. It then accepts byte commands and characters from a host over a valid/ready handshake, spacing each controller launch by a command-dependent settle delay. The downstream controller has no busy output, so this block paces all traffic purely by cycle counting.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_cmd_seq_if.sv | 23 ++
 rtl/lcd_delay.sv | 36 +++
 rtl/lcd_cmd_seq.sv | 122 ++++++++++++
 tb/tb_lcd_cmd_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: counter width, FSM states,
// HD44780 instruction bytes and the 4-bit-mode init ROM.
package lcd_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_READY,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_WAKE_8BIT = 8'h33;
  localparam logic [7:0] CMD_WAKE_4BIT = 8'h32;

  localparam logic [2:0] INIT_LAST = 3'd5;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = CMD_WAKE_8BIT;
      3'd1:    init_byte = CMD_WAKE_4BIT;
      3'd2:    init_byte = CMD_FUNC_4BIT;
      3'd3:    init_byte = CMD_DISP_ON;
      3'd4:    init_byte = CMD_ENTRY_INC;
      3'd5:    init_byte = CMD_CLEAR;
      default: init_byte = 8'h00;
    endcase
  endfunction

  function automatic logic init_long(input logic [2:0] idx);
    init_long = (idx == 3'd0) || (idx == 3'd5);
  endfunction

  // Clear/home (0x03 also decodes as home) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    is_long_cmd = !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Host byte handshake plus the signals driven into the nibble-level controller.
// slave = sequencer side, master = host/controller side.
interface lcd_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       lcd_start;

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data,
    output cmd_ready, init_done, lcd_rs, lcd_rw, lcd_data, lcd_start
  );

  modport master (
    output cmd_valid, cmd_rs, cmd_data,
    input  cmd_ready, init_done, lcd_rs, lcd_rw, lcd_data, lcd_start
  );
endinterface

// File: rtl/lcd_delay.sv
// Loadable down-counter shared by every wait state; load wins over decrement,
// and the count parks at zero. done is combinational from the count register.
module lcd_delay
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Paces init ROM and host bytes into the LCD controller by cycle counting.
// Host byte accepted at t launches at t+1; cmd_ready stays low until the settle delay expires.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] PWRUP_CYCLES = 20'd800000,
  parameter logic [CNT_W-1:0] SHORT_DELAY  = 20'd2500,
  parameter logic [CNT_W-1:0] LONG_DELAY   = 20'd100000
) (
  input logic          clk,
  input logic          rst,
  lcd_cmd_seq_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       start_q, start_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;

  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;

  lcd_delay #(
    .RST_VAL(PWRUP_CYCLES - 20'd1)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );

  // Output registers are loaded on the transition into an issue state, so
  // lcd_start and the new rs/data appear on the same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    start_d     = 1'b0;
    rs_d        = rs_q;
    data_d      = data_q;
    load        = 1'b0;
    load_val    = '0;
    case (state_q)
      ST_PWRUP: begin
        if (done) begin
          state_d = ST_INIT_ISSUE;
          start_d = 1'b1;
          rs_d    = 1'b0;
          data_d  = init_byte(idx_q);
        end
      end
      ST_INIT_ISSUE: begin
        load     = 1'b1;
        load_val = init_long(idx_q) ? (LONG_DELAY - 20'd1) : (SHORT_DELAY - 20'd1);
        state_d  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (done) begin
          if (idx_q == INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_READY;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT_ISSUE;
            start_d = 1'b1;
            rs_d    = 1'b0;
            data_d  = init_byte(idx_q + 3'd1);
          end
        end
      end
      ST_READY: begin
        if (bus.cmd_valid) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          rs_d    = bus.cmd_rs;
          data_d  = bus.cmd_data;
        end
      end
      ST_ISSUE: begin
        load     = 1'b1;
        load_val = is_long_cmd(rs_q, data_q) ? (LONG_DELAY - 20'd1) : (SHORT_DELAY - 20'd1);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      start_q     <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      start_q     <= start_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_READY);
  assign bus.init_done = init_done_q;
  assign bus.lcd_start = start_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: schedule-based reference model checked every cycle,
// directed scenarios with literal timing checks, then randomized host traffic.
module tb_lcd_cmd_seq;

  localparam int P = 100;
  localparam int S = 60;
  localparam int L = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_seq_if bus ();

  lcd_cmd_seq #(
    .PWRUP_CYCLES(20'd100),
    .SHORT_DELAY (20'd60),
    .LONG_DELAY  (20'd200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // cyc = number of rising edges since reset release (first edge is 1).
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Launch log for the directed checks.
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  logic       st_rs[$];
  always @(negedge clk) begin
    if (!rst && bus.lcd_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(bus.lcd_data);
      st_rs.push_back(bus.lcd_rs);
    end
  end

  // Reference model: init launch times follow from the delay table; a host byte
  // seen while ready launches next cycle and blocks ready for D+1 cycles.
  logic [7:0] init_b[6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
  int         init_d[6] = '{L, S, S, S, S, L};
  int         init_t[6];
  int         init_rdy;

  initial begin
    init_t[0] = P;
    for (int k = 1; k < 6; k++) init_t[k] = init_t[k-1] + init_d[k-1] + 1;
    init_rdy = init_t[5] + init_d[5] + 1;
  end

  int         ready_from = 0;
  int         host_at = -1;
  logic       h_rs = 1'b0;
  logic [7:0] h_dat = 8'h00;
  logic       m_rs = 1'b0;
  logic [7:0] m_dat = 8'h00;

  always @(negedge clk) begin : model
    logic e_start, e_rdy, e_done;
    e_start = 1'b0;
    e_rdy   = 1'b0;
    e_done  = 1'b0;
    if (rst) begin
      ready_from = init_rdy;
      host_at    = -1;
      m_rs       = 1'b0;
      m_dat      = 8'h00;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (cyc == init_t[k]) begin
          e_start = 1'b1;
          m_rs    = 1'b0;
          m_dat   = init_b[k];
        end
      end
      if (cyc == host_at) begin
        e_start = 1'b1;
        m_rs    = h_rs;
        m_dat   = h_dat;
      end
      e_done = (cyc >= init_rdy);
      e_rdy  = (cyc >= ready_from);
    end
    check("cycle_outputs{start,ready,done,rw,rs,data}",
          {19'd0, bus.lcd_start, bus.cmd_ready, bus.init_done, bus.lcd_rw, bus.lcd_rs, bus.lcd_data},
          {19'd0, e_start, e_rdy, e_done, 1'b0, m_rs, m_dat});
    if (!rst && e_rdy && bus.cmd_valid) begin
      h_rs       = bus.cmd_rs;
      h_dat      = bus.cmd_data;
      host_at    = cyc + 1;
      ready_from = cyc + ((!h_rs && h_dat >= 8'h01 && h_dat <= 8'h03) ? L : S) + 2;
    end
  end

  task automatic wait_accept(output int acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready_seen", {31'd0, bus.cmd_ready}, 32'd1);
    acc = cyc;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    wait_accept(acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called right after send(): counts cycles with cmd_ready low.
  task automatic measure_low(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("low_ready_seen", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic wait_done(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.init_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("init_done_seen", {31'd0, bus.init_done}, 32'd1);
    c = cyc;
  endtask

  int gaps_exp[5] = '{201, 61, 61, 61, 61};

  initial begin
    int acc, acc2, lowc, dc, base, nstart;
    logic       rs;
    logic [7:0] d;

    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, bus.lcd_start, bus.cmd_ready, bus.init_done, bus.lcd_rw,
                            bus.lcd_rs, bus.lcd_data}, 32'd0);
    #2 rst = 1'b0;

    // Power-up and init sequence.
    wait_done(dc);
    check("init_done_cycle", dc, 746);
    check("init_ready_with_done", {31'd0, bus.cmd_ready}, 32'd1);
    check("init_launch_count", st_cyc.size(), 6);
    check("first_start_cycle", st_cyc[0], 100);
    for (int k = 0; k < 6; k++) begin
      check("init_byte", st_dat[k], init_b[k]);
      check("init_rs", st_rs[k], 0);
      if (k > 0) check("init_gap", st_cyc[k] - st_cyc[k-1], gaps_exp[k-1]);
    end

    // Character byte, short delay.
    send(1'b1, 8'h41, acc);
    measure_low(lowc);
    check("char_start_cycle", st_cyc[$], acc + 1);
    check("char_data", st_dat[$], 8'h41);
    check("char_rs", st_rs[$], 1);
    check("char_ready_low", lowc, 61);
    check("rw_low", bus.lcd_rw, 0);

    // Held valid: clear then 'H' back to back.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h01;
    wait_accept(acc);
    @(posedge clk); #1;
    bus.cmd_rs   = 1'b1;
    bus.cmd_data = 8'h48;
    wait_accept(acc2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    measure_low(lowc);
    check("b2b_gap", st_cyc[$] - st_cyc[$-1], 202);
    check("b2b_accept_gap", acc2 - acc, 202);
    check("b2b_second_data", st_dat[$], 8'h48);

    // One-cycle valid blip while waiting is ignored.
    base = st_cyc.size();
    send(1'b1, 8'h42, acc);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'h55;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    measure_low(lowc);
    repeat (4) @(negedge clk);
    check("blip_start_count", st_cyc.size() - base, 1);

    // Long vs short delay decode.
    send(1'b0, 8'h03, acc);
    measure_low(lowc);
    check("home03_ready_low", lowc, 201);
    send(1'b1, 8'h01, acc);
    measure_low(lowc);
    check("char01_ready_low", lowc, 61);

    // Randomized host traffic, including stray blips while busy.
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      send(rs, d, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset in the middle of a long wait.
    send(1'b0, 8'h01, acc);
    repeat (20) @(negedge clk);
    check("pre_reset_done", bus.init_done, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {29'd0, bus.lcd_start, bus.cmd_ready, bus.init_done}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    base = st_cyc.size();
    wait_done(dc);
    nstart = st_cyc.size() - base;
    check("replay_launch_count", nstart, 6);
    check("replay_first_cycle", st_cyc[base], 100);
    check("replay_first_data", st_dat[base], 8'h33);
    check("replay_done_cycle", dc, 746);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
